// File: rtl/init_reset_sequencer_if.sv
// init_reset_sequencer_if
//   Groups the INIT monitor / CCC status inputs, the fault RETRY pulse, and the
//   staged reset and status outputs of init_reset_sequencer.
//   master : environment side. Drives the monitor flags and RETRY, and observes
//            the resets and status.
//   slave  : sequencer side. Observes the flags and RETRY, and drives the resets
//            and status.
//   Signals:
//     FABRIC_POR_N, DEVICE_INIT_DONE, XCVR_INIT_DONE, PLL_LOCK  async status flags
//     RETRY                                                     1-cycle pulse, CLK domain
//     CORE_RST_N, DP_RST_N                                      active-low fabric resets
//     READY, FAULT, STATE[2:0], LOCK_LOSS_CNT[7:0]              status
interface init_reset_sequencer_if;
    logic       FABRIC_POR_N;
    logic       DEVICE_INIT_DONE;
    logic       XCVR_INIT_DONE;
    logic       PLL_LOCK;
    logic       RETRY;
    logic       CORE_RST_N;
    logic       DP_RST_N;
    logic       READY;
    logic       FAULT;
    logic [2:0] STATE;
    logic [7:0] LOCK_LOSS_CNT;

    modport master (
        output FABRIC_POR_N, DEVICE_INIT_DONE, XCVR_INIT_DONE, PLL_LOCK, RETRY,
        input  CORE_RST_N, DP_RST_N, READY, FAULT, STATE, LOCK_LOSS_CNT
    );

    modport slave (
        input  FABRIC_POR_N, DEVICE_INIT_DONE, XCVR_INIT_DONE, PLL_LOCK, RETRY,
        output CORE_RST_N, DP_RST_N, READY, FAULT, STATE, LOCK_LOSS_CNT
    );
endinterface

// File: rtl/init_reset_sequencer.sv
// init_reset_sequencer
//   Sequences staged reset release for the digitizer fabric from the PolarFire
//   INIT monitor flags and the sampling PLL lock. Core logic is released first
//   and the ADC datapath second. The sequencer detects a PLL lock timeout and
//   loss of lock, re-sequences when lock recovers, and reports state and fault
//   status.
//   Ports:
//     CLK    system clock; the only clock
//     RESET  synchronous, active-high
//     bus    init_reset_sequencer_if.slave
//            inputs : FABRIC_POR_N, DEVICE_INIT_DONE, XCVR_INIT_DONE, PLL_LOCK (async), RETRY
//            outputs: CORE_RST_N, DP_RST_N, READY, FAULT, STATE, LOCK_LOSS_CNT (all registered)
module init_reset_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          USE_XCVR      = 1'b0,
    parameter int unsigned RELEASE_DELAY = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535
) (
    input  logic                   CLK,
    input  logic                   RESET,
    init_reset_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_POR       = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_REL_CORE  = 3'd3,
        S_REL_DP    = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > RELEASE_DELAY) ? LOCK_TIMEOUT : RELEASE_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_DELAY - 1);

    // Output bundle packing: {CORE_RST_N, DP_RST_N, READY, FAULT}.
    localparam logic [3:0] OUT_OFF   = 4'b0000;
    localparam logic [3:0] OUT_CORE  = 4'b1000;
    localparam logic [3:0] OUT_DP    = 4'b1100;
    localparam logic [3:0] OUT_RUN   = 4'b1110;
    localparam logic [3:0] OUT_FAULT = 4'b0001;

    // Synchroniser chain. Each entry packs {por_n, init_done, xcvr_done, lock}.
    logic [3:0] sync_q [SYNC_STAGES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {bus.FABRIC_POR_N, bus.DEVICE_INIT_DONE, bus.XCVR_INIT_DONE, bus.PLL_LOCK};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic por_n_s;
    logic init_done_s;
    logic xcvr_done_s;
    logic lock_s;
    logic init_ok;

    assign {por_n_s, init_done_s, xcvr_done_s, lock_s} = sync_q[SYNC_STAGES-1];
    assign init_ok = init_done_s & (xcvr_done_s | ~USE_XCVR);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       outs_q;
    logic [7:0]       lock_loss_q;

    // Each transition loads the output bundle of the destination state, so the
    // outputs change on the same edge as STATE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_POR;
            cnt_q       <= '0;
            outs_q      <= OUT_OFF;
            lock_loss_q <= '0;
        end else if (state_q != S_POR && !por_n_s) begin
            state_q <= S_POR;
            cnt_q   <= '0;
            outs_q  <= OUT_OFF;
        end else begin
            case (state_q)
                S_POR: begin
                    cnt_q  <= '0;
                    outs_q <= OUT_OFF;
                    if (por_n_s) begin
                        state_q <= S_WAIT_INIT;
                    end
                end
                S_WAIT_INIT: begin
                    if (init_ok) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= S_REL_CORE;
                        cnt_q   <= '0;
                        outs_q  <= OUT_CORE;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q <= S_FAULT;
                        cnt_q   <= '0;
                        outs_q  <= OUT_FAULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_REL_CORE: begin
                    if (!lock_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        outs_q  <= OUT_OFF;
                    end else if (cnt_q == REL_LAST) begin
                        state_q <= S_REL_DP;
                        cnt_q   <= '0;
                        outs_q  <= OUT_DP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_REL_DP: begin
                    if (!lock_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        outs_q  <= OUT_OFF;
                    end else if (cnt_q == REL_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        outs_q  <= OUT_RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        outs_q  <= OUT_OFF;
                        if (lock_loss_q != 8'hFF) begin
                            lock_loss_q <= lock_loss_q + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    if (bus.RETRY) begin
                        state_q <= S_WAIT_INIT;
                        cnt_q   <= '0;
                        outs_q  <= OUT_OFF;
                    end
                end
                default: begin
                    state_q <= S_POR;
                    cnt_q   <= '0;
                    outs_q  <= OUT_OFF;
                end
            endcase
        end
    end

    assign bus.CORE_RST_N    = outs_q[3];
    assign bus.DP_RST_N      = outs_q[2];
    assign bus.READY         = outs_q[1];
    assign bus.FAULT         = outs_q[0];
    assign bus.STATE         = state_q;
    assign bus.LOCK_LOSS_CNT = lock_loss_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// tb_init_reset_sequencer
//   Directed bench for init_reset_sequencer using RELEASE_DELAY=4, LOCK_TIMEOUT=100
//   and USE_XCVR=1. A behavioural model tracks the state number and the dwell
//   time in each state. The model sees the async flags through a history of raw
//   input samples. A compare process checks every DUT output against the model
//   on each falling edge. Directed checks pin both the DUT and the model to
//   hand-computed literals at the key cycles.
module tb_init_reset_sequencer;

    localparam int unsigned P_SYNC = 2;
    localparam bit          P_XCVR = 1'b1;
    localparam int unsigned P_RD   = 4;
    localparam int unsigned P_LT   = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    init_reset_sequencer_if bus();

    init_reset_sequencer #(
        .SYNC_STAGES   (P_SYNC),
        .USE_XCVR      (P_XCVR),
        .RELEASE_DELAY (P_RD),
        .LOCK_TIMEOUT  (P_LT)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model state: the state number, the cycles spent in it, and the loss count.
    int   m_state  = 0;
    int   m_dwell  = 0;
    int   m_llc    = 0;
    bit   model_ok = 1'b0;
    logic [3:0] hist [P_SYNC];   // raw {por,init,xcvr,lock} at earlier edges; [0] is newest

    always @(posedge clk) begin : model
        logic [3:0] s;
        int nxt;
        if (rst) begin
            m_state  = 0;
            m_dwell  = 0;
            m_llc    = 0;
            model_ok = 1'b1;
            for (int i = 0; i < P_SYNC; i++) hist[i] = '0;
        end else if (model_ok) begin
            s   = hist[P_SYNC-1];
            nxt = m_state;
            if (m_state != 0 && !s[3]) nxt = 0;
            else begin
                case (m_state)
                    0: if (s[3]) nxt = 1;
                    1: if (s[2] && (s[1] || !P_XCVR)) nxt = 2;
                    2: if (s[0]) nxt = 3; else if (m_dwell + 1 >= P_LT) nxt = 6;
                    3: if (!s[0]) nxt = 2; else if (m_dwell + 1 >= P_RD) nxt = 4;
                    4: if (!s[0]) nxt = 2; else if (m_dwell + 1 >= P_RD) nxt = 5;
                    5: if (!s[0]) begin
                           nxt = 2;
                           if (m_llc < 255) m_llc++;
                       end
                    6: if (bus.RETRY) nxt = 1;
                    default: nxt = 0;
                endcase
            end
            m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
            m_state = nxt;
            for (int i = P_SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {bus.FABRIC_POR_N, bus.DEVICE_INIT_DONE, bus.XCVR_INIT_DONE, bus.PLL_LOCK};
        end
    end

    always @(negedge clk) begin : compare
        logic e_core, e_dp, e_ready, e_fault;
        if (model_ok) begin
            e_core  = (m_state >= 3 && m_state <= 5);
            e_dp    = (m_state == 4 || m_state == 5);
            e_ready = (m_state == 5);
            e_fault = (m_state == 6);
            check("cycle",
                  {17'd0, bus.STATE, bus.CORE_RST_N, bus.DP_RST_N, bus.READY, bus.FAULT, bus.LOCK_LOSS_CNT},
                  {17'd0, 3'(m_state), e_core, e_dp, e_ready, e_fault, 8'(m_llc)});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The outs literal packs {CORE_RST_N, DP_RST_N, READY, FAULT}.
    task automatic pin(input string name, input int st, input logic [3:0] outs);
        check({name, "_state"}, 32'(bus.STATE), 32'(st));
        check({name, "_outs"}, {28'd0, bus.CORE_RST_N, bus.DP_RST_N, bus.READY, bus.FAULT}, {28'd0, outs});
        check({name, "_model"}, 32'(m_state), 32'(st));
    endtask

    task automatic wait_state(input string name, input int target, input int budget);
        int k = 0;
        while (bus.STATE !== 3'(target) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(bus.STATE), 32'(target));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete (%0d/%0d)", n_pass, n_total);
        $fatal(1);
    end

    initial begin : stim
        bus.FABRIC_POR_N     = 1'b0;
        bus.DEVICE_INIT_DONE = 1'b0;
        bus.XCVR_INIT_DONE   = 1'b0;
        bus.PLL_LOCK         = 1'b0;
        bus.RETRY            = 1'b0;
        tick(3);
        pin("reset", 0, 4'b0000);
        check("reset_llc", 32'(bus.LOCK_LOSS_CNT), 32'd0);
        rst = 1'b0;

        // Nominal bring-up
        bus.FABRIC_POR_N     = 1'b1;
        bus.DEVICE_INIT_DONE = 1'b1;
        bus.XCVR_INIT_DONE   = 1'b1;
        wait_state("t1_wait_lock", 2, 20);
        bus.PLL_LOCK = 1'b1;
        tick(2); pin("t1_pre_core", 2, 4'b0000);
        tick(1); pin("t1_core", 3, 4'b1000);
        tick(3); pin("t1_core_hold", 3, 4'b1000);
        tick(1); pin("t1_dp", 4, 4'b1100);
        tick(3); pin("t1_dp_hold", 4, 4'b1100);
        tick(1); pin("t1_run", 5, 4'b1110);

        // Lock loss in RUN and relock
        bus.PLL_LOCK = 1'b0;
        tick(2); pin("t3_pre_loss", 5, 4'b1110);
        tick(1); pin("t3_loss", 2, 4'b0000);
        check("t3_llc1", 32'(bus.LOCK_LOSS_CNT), 32'd1);
        bus.PLL_LOCK = 1'b1;
        tick(3); pin("t3_relock", 3, 4'b1000);
        wait_state("t3_run", 5, 20);

        // POR drop during REL_DP (second lock loss on the way there)
        bus.PLL_LOCK = 1'b0;
        wait_state("t4_wait_lock", 2, 10);
        bus.PLL_LOCK = 1'b1;
        wait_state("t4_rel_dp", 4, 20);
        bus.FABRIC_POR_N = 1'b0;
        tick(2); pin("t4_pre_por", 4, 4'b1100);
        tick(1); pin("t4_por", 0, 4'b0000);
        check("t4_llc_held", 32'(bus.LOCK_LOSS_CNT), 32'd2);
        bus.FABRIC_POR_N = 1'b1;
        wait_state("t4_reseq", 5, 40);
        check("t4_llc_after", 32'(bus.LOCK_LOSS_CNT), 32'd2);

        // 254 more losses: 256 in total, counter saturates at 255
        for (int i = 0; i < 254; i++) begin
            bus.PLL_LOCK = 1'b0;
            wait_state("t3_loop_loss", 2, 10);
            bus.PLL_LOCK = 1'b1;
            wait_state("t3_loop_run", 5, 20);
        end
        check("t3_llc_sat", 32'(bus.LOCK_LOSS_CNT), 32'd255);

        // RESET pulse in RUN
        rst = 1'b1;
        bus.PLL_LOCK = 1'b0;
        tick(1); pin("t6_reset", 0, 4'b0000);
        check("t6_llc", 32'(bus.LOCK_LOSS_CNT), 32'd0);
        rst = 1'b0;

        // Lock timeout, then RETRY
        wait_state("t2_wait_lock", 2, 20);
        tick(99); pin("t2_pre_timeout", 2, 4'b0000);
        tick(1);  pin("t2_fault", 6, 4'b0001);
        bus.RETRY = 1'b1;
        tick(1);
        bus.RETRY = 1'b0;
        pin("t2_retry", 1, 4'b0000);

        // XCVR gating with USE_XCVR=1
        rst = 1'b1;
        bus.XCVR_INIT_DONE = 1'b0;
        bus.PLL_LOCK       = 1'b1;
        tick(1);
        rst = 1'b0;
        wait_state("t5_wait_init", 1, 20);
        tick(10000); pin("t5_hold", 1, 4'b0000);
        bus.XCVR_INIT_DONE = 1'b1;
        tick(2); pin("t5_pre", 1, 4'b0000);
        tick(1); pin("t5_wait_lock", 2, 4'b0000);
        wait_state("t5_run", 5, 30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
